// File: rtl/grid_pass_scheduler.sv
// grid_pass_scheduler: sequences weight loading, image streaming, drain wait,
// psum capture and result emission for a NUM_ROWS x NUM_COLS PE grid.
// Optional macro GRID_SCHED_PSUM_ACCUM_EN: feed captured psums back into the
// grid on later passes and emit only once, after the final pass.
//
// state  | meaning
// IDLE   | waiting for start; cfg_passes sampled here
// LOAD_W | accepting NUM_ROWS weights, one row tag per handshake
// LOAD_X | accepting NUM_COLS images, one column tag per handshake
// DRAIN  | waiting DRAIN_CYCLES for the grid to settle, then capture psums
// EMIT   | streaming captured psums out, one column per handshake
module grid_pass_scheduler #(
    parameter int NUM_ROWS     = 12,
    parameter int NUM_COLS     = 14,
    parameter int DRAIN_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cfg_passes,
    output logic        busy,
    output logic        done,
    input  logic [15:0] w_data,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [15:0] x_data,
    input  logic        x_valid,
    output logic        x_ready,
    output logic [15:0] weight_val_in,
    output logic [3:0]  tag_row,
    output logic        valid_y,
    output logic [15:0] image_val_in,
    output logic [3:0]  tag_col,
    output logic        valid_x,
    input  logic [31:0] psum_outs [NUM_COLS],
    output logic [31:0] psum_ins  [NUM_COLS],
    output logic [31:0] res_data,
    output logic [3:0]  res_col,
    output logic        res_last,
    output logic        res_valid,
    input  logic        res_ready
);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, DRAIN, EMIT} state_t;

    localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);
    localparam logic [3:0] LAST_COL = 4'(NUM_COLS - 1);

    state_t      state_q, state_d;
    logic [7:0]  passes_q, passes_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  drain_q, drain_d;
    logic [31:0] buf_q [NUM_COLS];
    logic [31:0] buf_d [NUM_COLS];
    logic        busy_q, busy_d, done_q, done_d;
    logic        w_ready_q, w_ready_d, x_ready_q, x_ready_d;
    logic [15:0] weight_q, weight_d, image_q, image_d;
    logic [3:0]  tag_row_q, tag_row_d, tag_col_q, tag_col_d;
    logic        valid_y_q, valid_y_d, valid_x_q, valid_x_d;
    logic        res_valid_q, res_valid_d;
`ifdef GRID_SCHED_PSUM_ACCUM_EN
    logic        first_q, first_d;
`endif

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d     = state_q;
        passes_d    = passes_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        buf_d       = buf_q;
        done_d      = 1'b0;
        weight_d    = weight_q;
        tag_row_d   = tag_row_q;
        valid_y_d   = 1'b0;
        image_d     = image_q;
        tag_col_d   = tag_col_q;
        valid_x_d   = 1'b0;
`ifdef GRID_SCHED_PSUM_ACCUM_EN
        first_d     = first_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_passes == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = LOAD_W;
                        passes_d = cfg_passes;
                        idx_d    = '0;
`ifdef GRID_SCHED_PSUM_ACCUM_EN
                        first_d  = 1'b1;
`endif
                    end
                end
            end
            LOAD_W: begin
                if (w_valid && w_ready_q) begin
                    weight_d  = w_data;
                    tag_row_d = idx_q;
                    valid_y_d = 1'b1;
                    if (idx_q == LAST_ROW) begin
                        idx_d   = '0;
                        state_d = LOAD_X;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            LOAD_X: begin
                if (x_valid && x_ready_q) begin
                    image_d   = x_data;
                    tag_col_d = idx_q;
                    valid_x_d = 1'b1;
                    if (idx_q == LAST_COL) begin
                        idx_d   = '0;
                        drain_d = 8'(DRAIN_CYCLES);
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DRAIN: begin
                // The cycle carrying the final valid_x is not counted.
                if (!valid_x_q) begin
                    if (drain_q == 8'd1) begin
                        buf_d = psum_outs;
                        idx_d = '0;
`ifdef GRID_SCHED_PSUM_ACCUM_EN
                        if (passes_q > 8'd1) begin
                            passes_d = passes_q - 8'd1;
                            first_d  = 1'b0;
                            state_d  = LOAD_W;
                        end else begin
                            state_d = EMIT;
                        end
`else
                        state_d = EMIT;
`endif
                    end else begin
                        drain_d = drain_q - 8'd1;
                    end
                end
            end
            EMIT: begin
                if (res_valid_q && res_ready) begin
                    if (idx_q == LAST_COL) begin
                        idx_d = '0;
                        if (passes_q > 8'd1) begin
                            passes_d = passes_q - 8'd1;
                            state_d  = LOAD_W;
                        end else begin
                            passes_d = '0;
                            done_d   = 1'b1;
                            state_d  = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d != IDLE);
        w_ready_d   = (state_d == LOAD_W);
        x_ready_d   = (state_d == LOAD_X);
        res_valid_d = (state_d == EMIT);
    end

    // Sequencer state and registered outputs; reset abandons any pass silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            passes_q    <= '0;
            idx_q       <= '0;
            drain_q     <= '0;
            for (int c = 0; c < NUM_COLS; c++) buf_q[c] <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            w_ready_q   <= 1'b0;
            x_ready_q   <= 1'b0;
            weight_q    <= '0;
            tag_row_q   <= '0;
            valid_y_q   <= 1'b0;
            image_q     <= '0;
            tag_col_q   <= '0;
            valid_x_q   <= 1'b0;
            res_valid_q <= 1'b0;
`ifdef GRID_SCHED_PSUM_ACCUM_EN
            first_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            passes_q    <= passes_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            buf_q       <= buf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            w_ready_q   <= w_ready_d;
            x_ready_q   <= x_ready_d;
            weight_q    <= weight_d;
            tag_row_q   <= tag_row_d;
            valid_y_q   <= valid_y_d;
            image_q     <= image_d;
            tag_col_q   <= tag_col_d;
            valid_x_q   <= valid_x_d;
            res_valid_q <= res_valid_d;
`ifdef GRID_SCHED_PSUM_ACCUM_EN
            first_q     <= first_d;
`endif
        end
    end

    // Feedback psums: zero on the first pass, captured buffer afterwards.
    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
`ifdef GRID_SCHED_PSUM_ACCUM_EN
            psum_ins[c] = first_q ? 32'd0 : buf_q[c];
`else
            psum_ins[c] = 32'd0;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign w_ready       = w_ready_q;
    assign x_ready       = x_ready_q;
    assign weight_val_in = weight_q;
    assign tag_row       = tag_row_q;
    assign valid_y       = valid_y_q;
    assign image_val_in  = image_q;
    assign tag_col       = tag_col_q;
    assign valid_x       = valid_x_q;
    assign res_valid     = res_valid_q;
    assign res_col       = res_valid_q ? idx_q : 4'd0;
    assign res_data      = res_valid_q ? buf_q[idx_q] : 32'd0;
    assign res_last      = res_valid_q && (idx_q == LAST_COL);

endmodule

// File: tb/tb_grid_pass_scheduler.sv
// Scoreboard bench for grid_pass_scheduler with a behavioural PE-grid model.
module tb_grid_pass_scheduler;

    localparam int NR = 12;
    localparam int NC = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_passes = '0;
    logic        busy, done;
    logic [15:0] w_data = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [15:0] x_data = '0;
    logic        x_valid = 1'b0;
    logic        x_ready;
    logic [15:0] weight_val_in, image_val_in;
    logic [3:0]  tag_row, tag_col;
    logic        valid_y, valid_x;
    logic [31:0] psum_outs [NC];
    logic [31:0] psum_ins  [NC];
    logic [31:0] res_data;
    logic [3:0]  res_col;
    logic        res_last, res_valid;
    logic        res_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int stall_cycles = 0;
    int hold_cnt = 0;
    bit hold_en = 1'b0;
    bit add_mode = 1'b0;

    logic [19:0] wq [$];
    logic [19:0] xq [$];
    logic [36:0] rq [$];

    logic [15:0] gw [NR];
    logic [15:0] gx [NC];
    logic [31:0] wsum;

    grid_pass_scheduler #(.NUM_ROWS(NR), .NUM_COLS(NC), .DRAIN_CYCLES(12)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_passes(cfg_passes),
        .busy(busy), .done(done),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .weight_val_in(weight_val_in), .tag_row(tag_row), .valid_y(valid_y),
        .image_val_in(image_val_in), .tag_col(tag_col), .valid_x(valid_x),
        .psum_outs(psum_outs), .psum_ins(psum_ins),
        .res_data(res_data), .res_col(res_col), .res_last(res_last),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Grid model: latch tagged operands, psum = psum_in + (sum of weights) * image.
    always @(posedge clk) begin
        if (valid_y) gw[tag_row] <= weight_val_in;
        if (valid_x) gx[tag_col] <= image_val_in;
    end

    always_comb begin
        wsum = 32'd0;
        for (int r = 0; r < NR; r++) wsum = wsum + 32'(gw[r]);
        for (int c = 0; c < NC; c++)
            psum_outs[c] = add_mode ? psum_ins[c] + 32'd10 : psum_ins[c] + wsum * 32'(gx[c]);
    end

    // Result back-pressure: optionally stall 5 cycles while column 3 is offered.
    always @(posedge clk) begin
        #1;
        if (hold_en && res_valid && res_col == 4'd3 && hold_cnt < 5) begin
            res_ready = 1'b0;
            hold_cnt++;
        end else begin
            res_ready = 1'b1;
        end
    end

    // Monitor: compare grid drive and result streams against the scoreboard.
    always @(negedge clk) begin
        logic [19:0] e;
        logic [36:0] r;
        if (rst) begin
            if (valid_y) begin
                if (wq.size() == 0) check("valid_y_extra", 1, 0);
                else begin
                    e = wq.pop_front();
                    check("tag_row", 64'(tag_row), 64'(e[19:16]));
                    check("weight_val_in", 64'(weight_val_in), 64'(e[15:0]));
                end
            end
            if (valid_x) begin
                if (xq.size() == 0) check("valid_x_extra", 1, 0);
                else begin
                    e = xq.pop_front();
                    check("tag_col", 64'(tag_col), 64'(e[19:16]));
                    check("image_val_in", 64'(image_val_in), 64'(e[15:0]));
                end
            end
            if (res_valid) begin
                if (rq.size() == 0) check("res_extra", 1, 0);
                else begin
                    r = rq[0];
                    check("res_data", 64'(res_data), 64'(r[31:0]));
                    check("res_col", 64'(res_col), 64'(r[35:32]));
                    check("res_last", 64'(res_last), 64'(r[36]));
                    if (res_ready) void'(rq.pop_front());
                    else stall_cycles++;
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic drive_w(input bit stall);
        int k = 0;
        int cyc = 0;
        bit ph = 1'b1;
        while (k < NR && cyc < 2000) begin
            w_data  = 16'(k + 1);
            w_valid = stall ? ph : 1'b1;
            ph = !ph;
            @(negedge clk);
            if (w_valid && w_ready) begin
                wq.push_back({4'(k), w_data});
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        w_valid = 1'b0;
        if (k < NR) check("w_timeout", 64'(k), 64'(NR));
    endtask

    task automatic drive_x(input int n);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 2000) begin
            x_data  = 16'(k + 1);
            x_valid = 1'b1;
            @(negedge clk);
            if (x_valid && x_ready) begin
                xq.push_back({4'(k), x_data});
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        x_valid = 1'b0;
        if (k < n) check("x_timeout", 64'(k), 64'(n));
    endtask

    task automatic push_results(input bit accum, input logic [31:0] accum_val);
        for (int c = 0; c < NC; c++) begin
            logic [31:0] d;
            d = accum ? accum_val : 32'd78 * 32'(c + 1);
            rq.push_back({(c == NC - 1), 4'(c), d});
        end
    endtask

    task automatic run_cmd(input logic [7:0] n);
        start = 1'b1;
        cfg_passes = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, "_res_drained"}, 64'(rq.size()), 64'd0);
        check({tag, "_w_drained"}, 64'(wq.size()), 64'd0);
        check({tag, "_x_drained"}, 64'(xq.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        for (int i = 0; i < NR; i++) gw[i] = '0;
        for (int i = 0; i < NC; i++) gx[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_w_ready", 64'(w_ready), 0);
        check("rst_x_ready", 64'(x_ready), 0);
        check("rst_valid_y", 64'(valid_y), 0);
        check("rst_valid_x", 64'(valid_x), 0);
        check("rst_res_valid", 64'(res_valid), 0);
        check("rst_res_data", 64'(res_data), 0);
        check("rst_psum_ins", 64'(psum_ins[5]), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single pass, no stalls
        run_cmd(8'd1);
        check("s1_busy", 64'(busy), 1);
        drive_w(1'b0);
        drive_x(NC);
        push_results(1'b0, 32'd0);
        wait_done("s1");

        // Weight stream with w_valid toggling
        run_cmd(8'd1);
        drive_w(1'b1);
        drive_x(NC);
        push_results(1'b0, 32'd0);
        wait_done("s2");

        // Result back-pressure at column 3
        hold_en = 1'b1;
        hold_cnt = 0;
        stall_cycles = 0;
        run_cmd(8'd1);
        drive_w(1'b0);
        drive_x(NC);
        push_results(1'b0, 32'd0);
        wait_done("s3");
        check("s3_stall_cycles", 64'(stall_cycles), 64'd5);
        hold_en = 1'b0;

        // Zero-pass request
        dc = done_cnt;
        run_cmd(8'd0);
        check("s4_done", 64'(done), 1);
        check("s4_busy", 64'(busy), 0);
        @(posedge clk); #1;
        check("s4_done_clear", 64'(done), 0);
        check("s4_busy_idle", 64'(busy), 0);
        @(negedge clk);
        check("s4_done_count", 64'(done_cnt), 64'(dc + 1));
        @(posedge clk); #1;

        // Reset mid LOAD_X at column 7
        dc = done_cnt;
        run_cmd(8'd1);
        drive_w(1'b0);
        drive_x(7);
        rst = 1'b0;
        #1;
        check("s5_busy", 64'(busy), 0);
        check("s5_x_ready", 64'(x_ready), 0);
        check("s5_valid_x", 64'(valid_x), 0);
        check("s5_tag_col", 64'(tag_col), 0);
        check("s5_image", 64'(image_val_in), 0);
        check("s5_tag_row", 64'(tag_row), 0);
        check("s5_weight", 64'(weight_val_in), 0);
        check("s5_done", 64'(done), 0);
        wq.delete();
        xq.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("s5_no_done", 64'(done_cnt), 64'(dc));
        check("s5_idle_busy", 64'(busy), 0);
        run_cmd(8'd1);
        drive_w(1'b0);
        drive_x(NC);
        push_results(1'b0, 32'd0);
        wait_done("s5_restart");

`ifdef GRID_SCHED_PSUM_ACCUM_EN
        // Cross-pass accumulation: grid adds 10 each pass
        add_mode = 1'b1;
        dc = done_cnt;
        run_cmd(8'd3);
        for (int p = 0; p < 3; p++) begin
            drive_w(1'b0);
            drive_x(NC);
            check("s6_psum_ins_c0", 64'(psum_ins[0]), 64'(10 * p));
            check("s6_psum_ins_c13", 64'(psum_ins[NC - 1]), 64'(10 * p));
        end
        push_results(1'b1, 32'd30);
        wait_done("s6");
        check("s6_done_count", 64'(done_cnt), 64'(dc + 1));
        add_mode = 1'b0;
`else
        // Two passes, each emitting its own results
        dc = done_cnt;
        run_cmd(8'd2);
        for (int p = 0; p < 2; p++) begin
            drive_w(1'b0);
            drive_x(NC);
            check("s6_psum_ins_zero", 64'(psum_ins[3]), 64'd0);
            push_results(1'b0, 32'd0);
        end
        wait_done("s6");
        check("s6_done_count", 64'(done_cnt), 64'(dc + 1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_pass_scheduler.md
GRID_PASS_SCHEDULER -- requirements
Module: grid_pass_scheduler

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 12, meaning PE rows (weight tags).
REQ-002 SHALL have parameter NUM_COLS, default 14, meaning PE columns (image tags).
REQ-003 SHALL have parameter DRAIN_CYCLES, default 12, meaning wait cycles after the last image before psum capture, range 1-255.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset (asserted at 0).
REQ-006 SHALL have ports start (in, 1) and cfg_passes (in, 8): pass-count request, sampled in IDLE.
REQ-007 SHALL have ports busy (out, 1) and done (out, 1): busy is high outside IDLE; done is a one-cycle completion pulse.
REQ-008 SHALL have weight stream ports w_data (in, 16), w_valid (in, 1) and w_ready (out, 1).
REQ-009 SHALL have image stream ports x_data (in, 16), x_valid (in, 1) and x_ready (out, 1).
REQ-010 SHALL have grid drive ports, all outputs: weight_val_in (16), tag_row (4), valid_y (1), image_val_in (16), tag_col (4), valid_x (1).
REQ-011 SHALL have grid psum ports psum_outs (in, 32 x NUM_COLS, unpacked) and psum_ins (out, 32 x NUM_COLS, unpacked).
REQ-012 SHALL have result ports res_data (out, 32), res_col (out, 4), res_last (out, 1), res_valid (out, 1) and res_ready (in, 1).

Function
REQ-013 SHALL implement states IDLE, LOAD_W, LOAD_X, DRAIN and EMIT.
- IDLE -> LOAD_W when start=1 and cfg_passes!=0; cfg_passes is latched.
- LOAD_W -> LOAD_X after NUM_ROWS weight handshakes.
- LOAD_X -> DRAIN after NUM_COLS image handshakes.
- DRAIN -> EMIT after DRAIN_CYCLES cycles.
REQ-014 SHALL, when start=1 and cfg_passes=0 in IDLE, pulse done the next cycle and stay in IDLE.
REQ-015 SHALL ignore start while busy=1.
REQ-016 SHALL hold w_ready=1 only in LOAD_W and x_ready=1 only in LOAD_X; a handshake is valid&ready in the same cycle.
REQ-017 SHALL, on the k-th weight handshake (k=0..NUM_ROWS-1), drive in the next cycle: weight_val_in=w_data, tag_row=k, valid_y=1 for exactly one cycle.
REQ-018 SHALL, on the k-th image handshake, drive in the next cycle: image_val_in=x_data, tag_col=k, valid_x=1 for exactly one cycle.
REQ-019 SHALL hold valid_x/valid_y at 0 and data/tag outputs at their last values on stall cycles (valid=0); the row/column counters do not advance.
REQ-020 SHALL begin counting DRAIN on the cycle after the final valid_x, and on the DRAIN_CYCLES-th cycle capture all psum_outs[0..NUM_COLS-1] into an internal buffer.
REQ-021 SHALL, in EMIT, present buffer[c] on res_data with res_col=c, c ascending from 0, advancing only on res_valid&res_ready; res_last=1 with c=NUM_COLS-1.
REQ-022 SHALL hold res_data/res_col stable while res_valid=1 and res_ready=0.
REQ-023 SHALL, after the last EMIT handshake, go to LOAD_W if passes remain, otherwise pulse done and go to IDLE in the same transition.
REQ-024 SHALL use an 8-bit pass counter; 255 passes are legal with no wrap.

Reset
REQ-025 SHALL, while rst=0, force IDLE, clear all counters and the buffer, and drive every output to 0 (busy, done, w_ready, x_ready, valid_x, valid_y, res_valid, res_last, data, tags, psum_ins).
REQ-026 SHALL, on reset mid-pass, abandon the pass without emitting a done pulse; operation resumes only on a new start.

Configuration
REQ-027 SHALL support macro GRID_SCHED_PSUM_ACCUM_EN.
- Defined: psum_ins is zero in pass 0 and equals the captured buffer in later passes (cross-pass accumulation). EMIT occurs only after the final pass; non-final passes go DRAIN -> LOAD_W directly after capture.
- Undefined: psum_ins is always 0 and EMIT occurs every pass.

Verification
REQ-028 SHALL cover this scenario: cfg_passes=1, weights 1..12, images 1..14 with no stalls, grid model psum_out[c]=sum -> valid_y on 12 consecutive cycles with tag_row 0..11, valid_x on 14 cycles with tag_col 0..13, 14 results with res_last on col 13, then done.
REQ-029 SHALL cover this scenario: w_valid toggled every other cycle -> tag_row still 0..11 with no gaps or repeats, valid_y never high twice for one handshake.
REQ-030 SHALL cover this scenario: res_ready held 0 for 5 cycles at col 3 -> res_data/res_col stable for 5 cycles; col 4 follows only after ready.
REQ-031 SHALL cover this scenario: start with cfg_passes=0 -> done one cycle later, busy stays 0.
REQ-032 SHALL cover this scenario: rst=0 asserted during LOAD_X at column 7 -> all outputs 0 asynchronously, no done; a new start with cfg_passes=1 completes normally.
REQ-033 SHALL cover this scenario: GRID_SCHED_PSUM_ACCUM_EN defined, cfg_passes=3, grid adds 10 to psum_in -> psum_ins 0, 10, 20 across passes; a single EMIT with res_data=30 per column.
